cbf_bank_dispatcher: RTL and testbench

Distributes a single arbitrated k-mer query stream across NUM_BANKS independent counting-Bloom-filter (CBF) banks and returns results to the requester side in issue order. Sits between the master-side arbitrator, which supplies one tagged k-mer per cycle, and the CBF bank array. Per-bank credit counters bound outstanding queries. A global order queue plus per-bank result queues reassemble out-of-order bank responses into the original issue order.

---
 rtl/cbf_pkg.sv | 21 ++
 rtl/cbf_sync_fifo.sv | 57 +++++
 rtl/cbf_bank_dispatcher.sv | 147 ++++++++++++++
 tb/tb_cbf_bank_dispatcher.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cbf_pkg
// Purpose  : Shared widths and the order-queue entry type for the CBF bank
//            dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package cbf_pkg;

    localparam int KMER_WIDTH = 45;
    localparam int BANK_BITS  = 2;
    localparam int TAG_WIDTH  = 2;

    // One order-queue slot: which bank will answer, and who asked.
    typedef struct packed {
        logic [BANK_BITS-1:0] bank;
        logic [TAG_WIDTH-1:0] tag;
    } order_entry_t;

endpackage
`default_nettype wire

// File: rtl/cbf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cbf_sync_fifo
// Purpose  : Single-clock FIFO with extra-MSB pointers. The head is read
//            straight from storage (no output register). Pushes while full
//            and pops while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module cbf_sync_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] c_PTR_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DEPTH_BITS:0]   r_wr_ptr;
    logic [DEPTH_BITS:0]   r_rd_ptr;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]) &&
                       (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];

    // Pointer advance; fullness is judged on pre-edge state, so a same-cycle
    // pop never makes room for a push.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/cbf_bank_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : cbf_bank_dispatcher
// Purpose  : Steers one k-mer query per cycle to one of NUM_BANKS CBF banks,
//            bounds per-bank outstanding queries with credits, and returns
//            bank answers in original issue order.
// Revision : 1.0 - initial release
// ============================================================================
module cbf_bank_dispatcher #(
    parameter int NUM_BANKS        = 4,
    parameter int BANK_BITS        = cbf_pkg::BANK_BITS,
    parameter int KMER_WIDTH       = cbf_pkg::KMER_WIDTH,
    parameter int TAG_WIDTH        = cbf_pkg::TAG_WIDTH,
    parameter int MAX_OUT_BITS     = 3,
    parameter int ORDER_DEPTH_BITS = 5
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic [2*KMER_WIDTH-1:0]           inKmer,
    input  logic [TAG_WIDTH-1:0]              inTag,
    input  logic                              inValid,
    output logic                              inReady,
    output logic [NUM_BANKS*2*KMER_WIDTH-1:0] bankKmer,
    output logic [NUM_BANKS-1:0]              bankValid,
    input  logic [NUM_BANKS-1:0]              bankReady,
    input  logic [NUM_BANKS-1:0]              bankResultValid,
    input  logic [NUM_BANKS-1:0]              bankPositive,
    output logic                              outValid,
    output logic                              outPositive,
    output logic [TAG_WIDTH-1:0]              outTag,
    output logic                              errOverflow
);

    import cbf_pkg::*;

    localparam int c_KW   = 2 * KMER_WIDTH;
    localparam int c_OE_W = $bits(order_entry_t);
    localparam logic [MAX_OUT_BITS:0] c_CREDIT_MAX = {1'b1, {MAX_OUT_BITS{1'b0}}};
    localparam logic [MAX_OUT_BITS:0] c_CREDIT_ONE = {{MAX_OUT_BITS{1'b0}}, 1'b1};

    logic [BANK_BITS-1:0]    w_sel;
    logic                    w_accept;
    logic                    w_retire;
    logic                    w_order_full;
    logic                    w_order_empty;
    logic [c_OE_W-1:0]       w_head_raw;
    order_entry_t            w_head;
    order_entry_t            w_push_entry;
    logic [NUM_BANKS-1:0]    w_res_full;
    logic [NUM_BANKS-1:0]    w_res_empty;
    logic [NUM_BANKS-1:0]    w_res_head;
    logic [NUM_BANKS-1:0]    w_dec;
    logic [MAX_OUT_BITS:0]   r_credit [NUM_BANKS];
    logic                    r_out_valid;
    logic                    r_out_pos;
    logic [TAG_WIDTH-1:0]    r_out_tag;
    logic                    r_err;

    assign w_sel        = inKmer[BANK_BITS-1:0];
    assign inReady      = bankReady[w_sel] & (r_credit[w_sel] != c_CREDIT_MAX) & ~w_order_full;
    assign w_accept     = inValid & inReady;
    assign w_push_entry = '{bank: w_sel, tag: inTag};
    assign w_head       = order_entry_t'(w_head_raw);
    assign w_retire     = ~w_order_empty & ~w_res_empty[w_head.bank];

    // Dispatch decode: strobe and k-mer appear only on the selected bank.
    always_comb begin
        bankValid = '0;
        bankKmer  = '0;
        if (w_accept) begin
            bankValid[w_sel]                     = 1'b1;
            bankKmer[int'(w_sel) * c_KW +: c_KW] = inKmer;
        end
    end

    cbf_sync_fifo #(
        .DATA_WIDTH (c_OE_W),
        .DEPTH_BITS (ORDER_DEPTH_BITS)
    ) u_order_q (
        .clk     (clk),
        .rstb    (rstb),
        .i_push  (w_accept),
        .i_data  (w_push_entry),
        .i_pop   (w_retire),
        .o_head  (w_head_raw),
        .o_full  (w_order_full),
        .o_empty (w_order_empty)
    );

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign w_dec[b] = w_retire && (w_head.bank == BANK_BITS'(b));

            cbf_sync_fifo #(
                .DATA_WIDTH (1),
                .DEPTH_BITS (MAX_OUT_BITS)
            ) u_res_q (
                .clk     (clk),
                .rstb    (rstb),
                .i_push  (bankResultValid[b]),
                .i_data  (bankPositive[b]),
                .i_pop   (w_dec[b]),
                .o_head  (w_res_head[b]),
                .o_full  (w_res_full[b]),
                .o_empty (w_res_empty[b])
            );
        end
    endgenerate

    // Credit counters: +1 on dispatch, -1 on retire, unchanged when both.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int b = 0; b < NUM_BANKS; b++) r_credit[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (bankValid[b] && !w_dec[b])
                    r_credit[b] <= r_credit[b] + c_CREDIT_ONE;
                else if (!bankValid[b] && w_dec[b])
                    r_credit[b] <= r_credit[b] - c_CREDIT_ONE;
            end
        end
    end

    // Registered in-order result and sticky overflow flag.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_out_valid <= 1'b0;
            r_out_pos   <= 1'b0;
            r_out_tag   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_retire;
            if (w_retire) begin
                r_out_pos <= w_res_head[w_head.bank];
                r_out_tag <= w_head.tag;
            end
            if (|(bankResultValid & w_res_full)) r_err <= 1'b1;
        end
    end

    assign outValid    = r_out_valid;
    assign outPositive = r_out_pos;
    assign outTag      = r_out_tag;
    assign errOverflow = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cbf_bank_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbf_bank_dispatcher
// Purpose  : Self-checking bench for cbf_bank_dispatcher: a queue-level
//            reference model compared every cycle, plus directed scenarios
//            with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cbf_bank_dispatcher;

    localparam int NB = 4;
    localparam int KW = 90;

    logic            clk = 1'b0;
    logic            rstb = 1'b0;
    logic [KW-1:0]   inKmer = '0;
    logic [1:0]      inTag = '0;
    logic            inValid = 1'b0;
    logic            inReady;
    logic [NB*KW-1:0] bankKmer;
    logic [NB-1:0]   bankValid;
    logic [NB-1:0]   bankReady = '1;
    logic [NB-1:0]   bankResultValid = '0;
    logic [NB-1:0]   bankPositive = '0;
    logic            outValid;
    logic            outPositive;
    logic [1:0]      outTag;
    logic            errOverflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    cbf_bank_dispatcher dut (
        .clk             (clk),
        .rstb            (rstb),
        .inKmer          (inKmer),
        .inTag           (inTag),
        .inValid         (inValid),
        .inReady         (inReady),
        .bankKmer        (bankKmer),
        .bankValid       (bankValid),
        .bankReady       (bankReady),
        .bankResultValid (bankResultValid),
        .bankPositive    (bankPositive),
        .outValid        (outValid),
        .outPositive     (outPositive),
        .outTag          (outTag),
        .errOverflow     (errOverflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (queue level) ----------------
    typedef struct packed {
        logic [1:0] bank;
        logic [1:0] tag;
    } ent_t;

    ent_t order_q[$];
    bit   res_q [NB][$];
    bit         m_out_valid = 1'b0;
    bit         m_out_pos = 1'b0;
    logic [1:0] m_out_tag = '0;
    bit         m_err = 1'b0;

    // A bank's outstanding count is simply how many issued-but-unretired
    // queries in the order list belong to it.
    function automatic bit model_ready(input logic [1:0] s);
        int cnt = 0;
        foreach (order_q[i]) if (order_q[i].bank == s) cnt++;
        return bankReady[s] && (cnt < 8) && (order_q.size() < 32);
    endfunction

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            order_q.delete();
            for (int b = 0; b < NB; b++) res_q[b].delete();
            m_out_valid = 1'b0;
            m_out_pos   = 1'b0;
            m_out_tag   = '0;
            m_err       = 1'b0;
        end else begin
            bit acc;
            bit ret;
            bit full_pre [NB];
            acc = inValid && model_ready(inKmer[1:0]);
            for (int b = 0; b < NB; b++) full_pre[b] = (res_q[b].size() == 8);
            ret = (order_q.size() > 0) && (res_q[order_q[0].bank].size() > 0);
            m_out_valid = ret;
            if (ret) begin
                m_out_pos = res_q[order_q[0].bank].pop_front();
                m_out_tag = order_q[0].tag;
                void'(order_q.pop_front());
            end
            for (int b = 0; b < NB; b++) begin
                if (bankResultValid[b]) begin
                    if (full_pre[b]) m_err = 1'b1;
                    else res_q[b].push_back(bankPositive[b]);
                end
            end
            if (acc) order_q.push_back('{bank: inKmer[1:0], tag: inTag});
        end
    end

    task automatic chk(input string name, input logic [NB*KW-1:0] act, input logic [NB*KW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit              rdy;
            logic [NB-1:0]   exp_bv;
            logic [NB*KW-1:0] exp_bk;
            rdy    = model_ready(inKmer[1:0]);
            exp_bv = '0;
            exp_bk = '0;
            if (inValid && rdy) begin
                exp_bv = NB'(1) << inKmer[1:0];
                exp_bk = {{(NB-1)*KW{1'b0}}, inKmer} << (KW * int'(inKmer[1:0]));
            end
            chk("cyc_inReady", inReady, rdy);
            chk("cyc_bankValid", bankValid, exp_bv);
            chk("cyc_bankKmer", bankKmer, exp_bk);
            chk("cyc_outValid", outValid, m_out_valid);
            chk("cyc_errOverflow", errOverflow, m_err);
            if (m_out_valid) begin
                chk("cyc_outPositive", outPositive, m_out_pos);
                chk("cyc_outTag", outTag, m_out_tag);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inValid         = 1'b0;
        bankResultValid = '0;
        bankPositive    = '0;
    endtask

    task automatic mk(input logic [1:0] bank, input int n);
        inKmer = {32'hC0DE0000 + 32'(n), 32'h12345678, 24'h9ABCDE, bank};
        inTag  = 2'(n);
    endtask

    task automatic do_reset();
        idle();
        rstb = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bankReady = '1;
        do_reset();
        chk_en = 1'b1;
        chk("rst_outValid", outValid, 0);
        chk("rst_outTag", outTag, 0);
        chk("rst_err", errOverflow, 0);

        // Single query to bank 2, reply three cycles later.
        mk(2'b10, 0);
        inTag = 2'd3;
        bankReady = 4'b1011;
        #1 chk("t1_bank_not_ready", inReady, 0);
        bankReady = 4'hF;
        inValid = 1'b1;
        #1;
        chk("t1_ready", inReady, 1);
        chk("t1_bankValid", bankValid, 4'b0100);
        chk("t1_slice2", bankKmer[2*KW +: KW], inKmer);
        chk("t1_low_slices", bankKmer[2*KW-1:0], 0);
        chk("t1_high_slice", bankKmer[4*KW-1:3*KW], 0);
        tick();
        idle();
        tick();
        tick();
        bankResultValid = 4'b0100;
        bankPositive    = 4'b0100;
        tick();
        idle();
        chk("t1_no_early_out", outValid, 0);
        tick();
        chk("t1_outValid", outValid, 1);
        chk("t1_outPositive", outPositive, 1);
        chk("t1_outTag", outTag, 3);
        tick();
        chk("t1_out_done", outValid, 0);

        // Bank 0 then bank 1; bank 1 answers first.
        inValid = 1'b1;
        mk(2'b00, 0);
        tick();
        mk(2'b01, 1);
        tick();
        idle();
        bankResultValid = 4'b0010;
        bankPositive    = 4'b0000;
        tick();
        bankResultValid = 4'b0001;
        bankPositive    = 4'b0001;
        tick();
        idle();
        chk("t2_wait", outValid, 0);
        tick();
        chk("t2_first_valid", outValid, 1);
        chk("t2_first_pos", outPositive, 1);
        chk("t2_first_tag", outTag, 0);
        tick();
        chk("t2_second_valid", outValid, 1);
        chk("t2_second_pos", outPositive, 0);
        chk("t2_second_tag", outTag, 1);
        tick();
        chk("t2_done", outValid, 0);

        // Credit limit on bank 3.
        do_reset();
        inValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mk(2'b11, i);
            tick();
        end
        mk(2'b11, 8);
        #1 chk("t3_bank3_blocked", inReady, 0);
        mk(2'b00, 9);
        #1 chk("t3_bank0_ok", inReady, 1);
        tick();
        inValid = 1'b0;
        bankResultValid = 4'b1000;
        bankPositive    = 4'b1000;
        tick();
        idle();
        mk(2'b11, 10);
        #1 chk("t3_still_blocked", inReady, 0);
        tick();
        chk("t3_resumed", inReady, 1);
        chk("t3_retired", outValid, 1);
        chk("t3_retired_tag", outTag, 0);

        // Fill the order queue with 32 queries.
        do_reset();
        inValid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mk(2'(i), i);
            tick();
        end
        mk(2'b00, 40);
        #1 chk("t4_full_blocked", inReady, 0);
        inValid = 1'b0;
        bankResultValid = 4'b0001;
        bankPositive    = 4'b0000;
        tick();
        idle();
        #1 chk("t4_no_write_through", inReady, 0);
        tick();
        chk("t4_ready_restored", inReady, 1);
        chk("t4_retire_valid", outValid, 1);
        chk("t4_retire_pos", outPositive, 0);

        // Unsolicited results overflow bank 1's queue.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            bankResultValid = 4'b0010;
            bankPositive    = 4'b0010;
            tick();
            if (i == 8) chk("t5_no_err_at_8", errOverflow, 0);
            if (i == 9) chk("t5_err_at_9", errOverflow, 1);
        end
        idle();
        tick();
        tick();
        chk("t5_err_sticky", errOverflow, 1);
        do_reset();
        chk("t5_err_cleared", errOverflow, 0);

        // Reset with outstanding queries.
        inValid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            mk(2'(i), i);
            tick();
        end
        idle();
        bankResultValid = 4'b0010;
        bankPositive    = 4'b0010;
        tick();
        idle();
        tick();
        chk("t6_pre_valid", outValid, 1);
        chk("t6_pre_tag", outTag, 1);
        rstb = 1'b0;
        #1;
        chk("t6_rst_valid", outValid, 0);
        chk("t6_rst_pos", outPositive, 0);
        chk("t6_rst_tag", outTag, 0);
        mk(2'b10, 0);
        bankReady = 4'b1011;
        #1 chk("t6_rst_ready_follows_bank", inReady, 0);
        bankReady = 4'hF;
        #1 chk("t6_rst_ready", inReady, 1);
        tick();
        rstb = 1'b1;
        mk(2'b10, 7);
        inValid = 1'b1;
        #1 chk("t6_accept", bankValid, 4'b0100);
        tick();
        idle();
        bankResultValid = 4'b0100;
        bankPositive    = 4'b0100;
        tick();
        idle();
        tick();
        chk("t6_new_valid", outValid, 1);
        chk("t6_new_pos", outPositive, 1);
        chk("t6_new_tag", outTag, 3);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
